// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline stages.
package pipe_pkg;

  typedef logic [15:0] word_t;

  // Bubble word presented to IF/ID when no real instruction is available.
  localparam word_t NOP_INSTR = 16'hF000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    HALTED
  } fetch_state_t;

  // Sequential PC advance; wraps naturally at 16 bits.
  function automatic word_t pc_inc(input word_t pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instruction, next PC} buffer. It parks a response that arrives
// while the downstream stage is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        invalidate,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc
);

  // Capture on load; invalidate wins so a redirect can never leak a stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload is reset along with the valid bit. A single entry is a
    // few flops rather than a RAM, and known reset values keep X out of the
    // output mux.
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It owns the PC, keeps at most one request
// outstanding to a variable-latency instruction memory, and feeds IF/ID with
// instructions or NOP bubbles.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_hazard,
  input  logic        PC_hazard,
  input  logic [15:0] branch_target,
  input  logic        call,
  input  logic [15:0] call_addr,
  input  logic        halt,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] instruction_out,
  output logic [15:0] PC_out,
  output logic        fetch_valid
);
  import pipe_pkg::*;

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         discard_q, discard_d;
  word_t        instr_q, instr_d;
  word_t        pc_out_q, pc_out_d;
  logic         fetch_valid_q, fetch_valid_d;

  logic         redirect;
  word_t        redirect_pc;
  logic         buf_load, buf_inval, buf_valid;
  word_t        buf_instr, buf_pc;

  // A branch redirect outranks a call when both arrive together.
  assign redirect    = PC_hazard | call;
  assign redirect_pc = PC_hazard ? branch_target : call_addr;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .invalidate (buf_inval),
    .instr_in   (imem_data),
    .pc_in      (pc_inc(pc_q)),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  // State, PC and IF/ID output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and process order cannot matter.
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Next-state, next-PC and output selection in priority order halt > redirect > normal.
  always_comb begin
    // NOTE: every signal assigned below gets a default first. Without a
    // default, any path that skipped an assignment would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    fetch_valid_d = fetch_valid_q;
    buf_load      = 1'b0;
    buf_inval     = 1'b0;
    imem_rd_en    = 1'b0;

    if (state_q == HALTED) begin
      instr_d       = NOP_INSTR;
      fetch_valid_d = 1'b0;
    end else if (halt) begin
      state_d       = HALTED;
      discard_d     = 1'b0;
      buf_inval     = 1'b1;
      instr_d       = NOP_INSTR;
      fetch_valid_d = 1'b0;
    end else if (redirect) begin
      // A request is not issued for the old PC when a redirect lands in FETCH.
      // That keeps a single request outstanding when the new target is fetched.
      pc_d          = redirect_pc;
      instr_d       = NOP_INSTR;
      fetch_valid_d = 1'b0;
      buf_inval     = 1'b1;
      if (state_q == WAIT && !imem_valid) begin
        state_d   = WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = FETCH;
        discard_d = 1'b0;
      end
    end else begin
      // Bubble unless this cycle delivers something or downstream is stalled.
      if (!data_hazard) begin
        instr_d       = NOP_INSTR;
        fetch_valid_d = 1'b0;
      end
      case (state_q)
        FETCH: begin
          imem_rd_en = 1'b1;
          state_d    = WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            state_d = FETCH;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              pc_d = pc_inc(pc_q);
              if (!data_hazard) begin
                instr_d       = imem_data;
                pc_out_d      = pc_inc(pc_q);
                fetch_valid_d = 1'b1;
              end else begin
                buf_load = 1'b1;
                state_d  = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!data_hazard) begin
            if (buf_valid) begin
              instr_d       = buf_instr;
              pc_out_d      = buf_pc;
              fetch_valid_d = 1'b1;
            end
            buf_inval = 1'b1;
            state_d   = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr       = pc_q;
  assign instruction_out = instr_q;
  assign PC_out          = pc_out_q;
  assign fetch_valid     = fetch_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Each table row describes one clock cycle:
// the inputs driven in that cycle and the outputs expected during it.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_hazard, PC_hazard, call, halt;
  logic [15:0] branch_target, call_addr;
  logic        imem_rd_en;
  logic [15:0] imem_addr, imem_data;
  logic        imem_valid;
  logic [15:0] instruction_out, PC_out;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] NOP = 16'hF000;

  if_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_hazard     (data_hazard),
    .PC_hazard       (PC_hazard),
    .branch_target   (branch_target),
    .call            (call),
    .call_addr       (call_addr),
    .halt            (halt),
    .imem_rd_en      (imem_rd_en),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_valid      (imem_valid),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .fetch_valid     (fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dh, ph, cl, ht, vld;
    logic [15:0] data, bt, ca;
    logic        rd;
    logic [15:0] addr, ins, pco;
    logic        fv;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctl = {data_hazard, PC_hazard, call, halt, imem_valid}
  task automatic add(input logic [4:0] ctl, input logic [15:0] data, input logic [15:0] bt,
                     input logic [15:0] ca, input logic rd, input logic [15:0] addr,
                     input logic [15:0] ins, input logic [15:0] pco, input logic fv);
    vec_t v;
    {v.dh, v.ph, v.cl, v.ht, v.vld} = ctl;
    v.data = data; v.bt = bt; v.ca = ca;
    v.rd = rd; v.addr = addr; v.ins = ins; v.pco = pco; v.fv = fv;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    data_hazard = 0; PC_hazard = 0; call = 0; halt = 0; imem_valid = 0;
    imem_data = '0; branch_target = '0; call_addr = '0;
  endtask

  // Apply every queued row on its own cycle, compare mid-cycle, then empty the queue.
  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      data_hazard = vecs[i].dh; PC_hazard = vecs[i].ph; call = vecs[i].cl;
      halt = vecs[i].ht; imem_valid = vecs[i].vld; imem_data = vecs[i].data;
      branch_target = vecs[i].bt; call_addr = vecs[i].ca;
      #1;
      check($sformatf("%s%0d rd_en", tag, i), {15'd0, imem_rd_en}, {15'd0, vecs[i].rd});
      check($sformatf("%s%0d addr", tag, i), imem_addr, vecs[i].addr);
      check($sformatf("%s%0d instr", tag, i), instruction_out, vecs[i].ins);
      check($sformatf("%s%0d pc_out", tag, i), PC_out, vecs[i].pco);
      check($sformatf("%s%0d fvalid", tag, i), {15'd0, fetch_valid}, {15'd0, vecs[i].fv});
    end
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset instr", instruction_out, NOP);
    check("reset pc_out", PC_out, 16'h0000);
    check("reset fvalid", {15'd0, fetch_valid}, 16'h0000);
    check("reset addr", imem_addr, 16'h0000);

    @(posedge clk); #1 rst_n = 1'b1;

    //   ctl      data      bt        ca        rd addr      instr     pc_out    fv
    // 1-cycle memory: first instruction.
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, NOP,      16'h0000, 0); // c0 FETCH
    add(5'b00001, 16'h1234, 16'h0000, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 0); // c1 resp
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0001, 16'h1234, 16'h0001, 1); // c2
    // 3-cycle memory latency, bubbles in the gaps.
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0001, NOP,      16'h0001, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0001, NOP,      16'h0001, 0);
    add(5'b00001, 16'h1111, 16'h0000, 16'h0000, 0, 16'h0001, NOP,      16'h0001, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0002, 16'h1111, 16'h0002, 1);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, NOP,      16'h0002, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0002, NOP,      16'h0002, 0);
    add(5'b00001, 16'h2222, 16'h0000, 16'h0000, 0, 16'h0002, NOP,      16'h0002, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0003, 16'h2222, 16'h0003, 1);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0003, NOP,      16'h0003, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0003, NOP,      16'h0003, 0);
    add(5'b00001, 16'h3333, 16'h0000, 16'h0000, 0, 16'h0003, NOP,      16'h0003, 0);
    // data_hazard for 5 cycles; the response lands in the hold buffer.
    add(5'b10000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0004, 16'h3333, 16'h0004, 1); // c14
    add(5'b10001, 16'h4444, 16'h0000, 16'h0000, 0, 16'h0004, 16'h3333, 16'h0004, 1);
    add(5'b10000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0005, 16'h3333, 16'h0004, 1);
    add(5'b10000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0005, 16'h3333, 16'h0004, 1);
    add(5'b10000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0005, 16'h3333, 16'h0004, 1);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0005, 16'h3333, 16'h0004, 1); // release
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0005, 16'h4444, 16'h0005, 1); // c20
    // Branch during WAIT; the late response is dropped.
    add(5'b01000, 16'h0000, 16'h0040, 16'h0000, 0, 16'h0005, NOP,      16'h0005, 0); // c21
    add(5'b00001, 16'hBAD1, 16'h0000, 16'h0000, 0, 16'h0040, NOP,      16'h0005, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0040, NOP,      16'h0005, 0);
    add(5'b00001, 16'h4040, 16'h0000, 16'h0000, 0, 16'h0040, NOP,      16'h0005, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0041, 16'h4040, 16'h0041, 1); // c25
    // Branch and call together: branch_target wins.
    add(5'b01100, 16'h0000, 16'h0040, 16'h0800, 0, 16'h0041, NOP,      16'h0041, 0); // c26
    add(5'b00001, 16'hDEAD, 16'h0000, 16'h0000, 0, 16'h0040, NOP,      16'h0041, 0);
    // Call alone in FETCH: no request for the old PC.
    add(5'b00100, 16'h0000, 16'h0000, 16'h0800, 0, 16'h0040, NOP,      16'h0041, 0); // c28
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0800, NOP,      16'h0041, 0);
    // Response in the redirect cycle itself is dropped; redirect to FFFF.
    add(5'b01001, 16'h5555, 16'hFFFF, 16'h0000, 0, 16'h0800, NOP,      16'h0041, 0); // c30
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'hFFFF, NOP,      16'h0041, 0);
    add(5'b00001, 16'h7777, 16'h0000, 16'h0000, 0, 16'hFFFF, NOP,      16'h0041, 0);
    // Wrap: PC_out = 0, next address 0. The stall holds the outputs.
    add(5'b10000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h7777, 16'h0000, 1); // c33
    // A call under data_hazard still bubbles the outputs.
    add(5'b10100, 16'h0000, 16'h0000, 16'h0100, 0, 16'h0000, 16'h7777, 16'h0000, 1); // c34
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0100, NOP,      16'h0000, 0);
    add(5'b00001, 16'h9999, 16'h0000, 16'h0000, 0, 16'h0100, NOP,      16'h0000, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0100, NOP,      16'h0000, 0);
    add(5'b00001, 16'hAAAA, 16'h0000, 16'h0000, 0, 16'h0100, NOP,      16'h0000, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0101, 16'hAAAA, 16'h0101, 1); // c39
    // Halt together with a branch in WAIT: halt wins, PC unchanged.
    add(5'b01010, 16'h0000, 16'h0200, 16'h0000, 0, 16'h0101, NOP,      16'h0101, 0); // c40
    run_vecs("v");

    // Halted: stray responses and redirects change nothing for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_idle();
      imem_valid = i[0];
      imem_data  = 16'(i * 16'h0111);
      PC_hazard  = (i == 5);
      branch_target = 16'h0300;
      #1;
      check($sformatf("halt%0d rd_en", i), {15'd0, imem_rd_en}, 16'h0000);
      check($sformatf("halt%0d addr", i), imem_addr, 16'h0101);
      check($sformatf("halt%0d instr", i), instruction_out, NOP);
      check($sformatf("halt%0d fvalid", i), {15'd0, fetch_valid}, 16'h0000);
    end

    // Asynchronous reset mid-cycle takes effect immediately.
    @(posedge clk);
    #3;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("async instr", instruction_out, NOP);
    check("async pc_out", PC_out, 16'h0000);
    check("async fvalid", {15'd0, fetch_valid}, 16'h0000);
    check("async addr", imem_addr, 16'h0000);
    check("async rd_en", {15'd0, imem_rd_en}, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    imem_valid = 1'b1;
    imem_data  = 16'hBEEF;
    rst_n = 1'b1;

    // A stale response in the first cycle after reset is ignored.
    add(5'b00001, 16'hBEEF, 16'h0000, 16'h0000, 1, 16'h0000, NOP,      16'h0000, 0);
    add(5'b00001, 16'h1357, 16'h0000, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 0);
    add(5'b00000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0001, 16'h1357, 16'h0001, 1);
    run_vecs("r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and issues one read at a time to a variable-latency instruction memory.
- Presents each fetched instruction and its next-sequential PC to the IF/ID pipeline register, and inserts NOP bubbles while waiting, stalled or redirecting.
- Accepts stall, branch-redirect, call-redirect and halt from later stages.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hF000, bubble word driven on instruction_out when no valid instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_hazard  in  1  downstream stall; hold all outputs and the PC.
- PC_hazard  in  1  taken branch/jump; redirect to branch_target.
- branch_target  in  16  redirect address for PC_hazard.
- call  in  1  call redirect to call_addr.
- call_addr  in  16  full call target address.
- halt  in  1  halt fetch until reset.
- imem_rd_en  out  1  read request, high for exactly one cycle per request.
- imem_addr  out  16  read address, equal to pc_q.
- imem_data  in  16  read data.
- imem_valid  in  1  read data valid; one pulse per request, at least 1 cycle after imem_rd_en.
- instruction_out  out  16  fetched instruction or NOP_INSTR; feeds IF/ID instruction_in.
- PC_out  out  16  fetched PC+1; feeds IF/ID PC_in.
- fetch_valid  out  1  instruction_out is a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=FETCH, discard=0.
  - instruction_out=NOP_INSTR, PC_out=0, fetch_valid=0, hold buffer cleared.
- States: FETCH, WAIT, HOLD, HALTED.
- FETCH: imem_rd_en=1, imem_addr=pc_q; next state WAIT. Outputs show NOP_INSTR/fetch_valid=0 unless data_hazard holds them.
- WAIT: imem_rd_en=0. On imem_valid:
  - discard=1: drop the data, clear discard, go to FETCH.
  - data_hazard=0: instruction_out=imem_data, PC_out=pc_q+1, fetch_valid=1, pc_q=pc_q+1, go to FETCH.
  - data_hazard=1: latch data and pc_q+1 into the hold buffer, pc_q=pc_q+1, go to HOLD.
- HOLD: outputs frozen. On the first cycle with data_hazard=0, drive the buffer to the outputs with fetch_valid=1, then go to FETCH.
- Each instruction therefore takes at least 2 cycles (FETCH plus 1 or more WAIT cycles). Throughput is 1 instruction per (mem latency + 1) cycles.
- Bubble rule: any cycle in which data_hazard=0 and no instruction is delivered loads instruction_out=NOP_INSTR and fetch_valid=0. PC_out holds its last value.
- data_hazard=1: instruction_out, PC_out and fetch_valid hold. An in-flight response is still captured (WAIT goes to HOLD).
- Redirect priority: rst_n > halt > PC_hazard > call > data_hazard > sequential.
- Redirect cycle (PC_hazard or call, no halt):
  - pc_q=target; instruction_out=NOP_INSTR and fetch_valid=0, even if data_hazard=1.
  - Hold buffer invalidated.
  - If in WAIT and imem_valid is not asserted this cycle: set discard=1 and stay in WAIT.
  - Otherwise go to FETCH. A response arriving in the redirect cycle itself is dropped.
- PC_hazard and call together: branch_target wins.
- halt:
  - Enters HALTED, outputs NOP_INSTR/fetch_valid=0, imem_rd_en=0 forever; only rst_n exits.
  - Outstanding responses are ignored.
  - halt simultaneous with a redirect: halt wins and pc_q is unchanged.
- Wrap: pc_q+1 is mod 2^16, so 16'hFFFF advances to 16'h0000 (PC_out=0).
- Reset mid-WAIT: returns to FETCH at RESET_PC. A stale imem_valid in the first cycle after reset is ignored because the state is FETCH.
- Invariants: at most one outstanding request; imem_rd_en is never high in WAIT, HOLD or HALTED.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR constant, 16'hF000.
  - the fetch_state_t enum {FETCH, WAIT, HOLD, HALTED}.
  - word_t typedef, logic [15:0].
- One natural sub-module, fetch_hold_buf: a 1-entry {instr, pc} register with load/invalidate/valid.
- Next-PC mux and FSM live in the top.

Test Plan:
- Reset release with 1-cycle memory returning 16'h1234 at addr 0 → imem_rd_en pulses at cycle 0; instruction_out=16'h1234, PC_out=16'h0001, fetch_valid=1 after cycle 2; next request addr=1.
- 3-cycle memory latency, 4 instructions → NOP_INSTR with fetch_valid=0 on every gap cycle; addresses 0,1,2,3 in order; never two requests outstanding.
- data_hazard held 5 cycles while a response arrives → outputs frozen, response buffered (HOLD); on release the buffered instr appears once, with no loss or duplication.
- PC_hazard with branch_target=16'h0040 during WAIT → NOP_INSTR next cycle; late response dropped; next imem_addr=16'h0040. Repeat with call plus PC_hazard together: target 16'h0040 wins over call_addr.
- pc_q=16'hFFFF sequential fetch → PC_out=16'h0000, next imem_addr=16'h0000.
- halt asserted in WAIT → no further imem_rd_en for 20 cycles, outputs NOP_INSTR; async rst_n pulse mid-cycle → immediate reset values, fetch restarts at RESET_PC.
